// File: rtl/vector_response_checker_pkg.sv
// Shared types and default sizing for the adder response checker.
// Holds the run-state encoding and a helper for sizing the expected-word table address.
package vector_check_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 9;
  localparam int DEF_IDX_W  = 7;
  localparam int DEF_ERR_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Narrowest address that reaches every table entry; never zero bits wide.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vector_response_checker_if.sv
// Valid/ready response stream from the adder DUT into the checker.
// The source side drives valid and data; the checker drives ready.
interface vector_response_checker_if
  import vector_check_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (output rsp_valid, output rsp_data, input rsp_ready);
  modport slave  (input rsp_valid, input rsp_data, output rsp_ready);
endinterface

// File: rtl/vector_response_checker_ram.sv
// Expected-word table: one write port, one combinational read port, contents survive reset.
// Reads at or beyond DEPTH return zero so the DONE-state index never reaches past the array.
module expected_vector_ram
  import vector_check_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int AW = addrWidth(DEPTH);
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = ({1'b0, raddr_i} < DEPTH_X) ? mem_q[raddr_i[AW-1:0]] : '0;

endmodule

// File: rtl/vector_response_checker.sv
// Judges DUT responses against a loaded table of expected words, in order, one run at a time,
// and reports error count, first failing index, the latest mismatch and overall pass/fail.
module vector_response_checker
  import vector_check_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vector_response_checker_if.slave rsp,
  input  logic                     exp_we_i,
  input  logic [IDX_W-1:0]         exp_addr_i,
  input  logic [DATA_W-1:0]        exp_wdata_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [IDX_W-1:0]         vec_count_o,
  output logic [ERR_W-1:0]         err_count_o,
  output logic                     first_err_valid_o,
  output logic [IDX_W-1:0]         first_err_idx_o,
  output logic                     mm_pulse_o,
  output logic [DATA_W-1:0]        mm_got_o,
  output logic [DATA_W-1:0]        mm_exp_o
);
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] LAST_X  = (IDX_W+1)'(DEPTH-1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  vec_count_q, vec_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [IDX_W-1:0]  first_err_idx_q, first_err_idx_d;
  logic              mm_pulse_q, mm_pulse_d;
  logic [DATA_W-1:0] mm_got_q, mm_got_d;
  logic [DATA_W-1:0] mm_exp_q, mm_exp_d;

  logic              running;
  logic              runEntry;
  logic              accept;
  logic              lastAccept;
  logic              mismatch;
  logic              tableWe;
  logic [DATA_W-1:0] expData;

  assign running    = (state_q == ST_RUN);
  assign runEntry   = !running && start_i;
  assign accept     = running && rsp.rsp_valid;
  assign lastAccept = accept && ({1'b0, vec_count_q} == LAST_X);
  assign mismatch   = accept && (rsp.rsp_data != expData);
  assign tableWe    = exp_we_i && !running && ({1'b0, exp_addr_i} < DEPTH_X);

  expected_vector_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (clk),
    .we_i    (tableWe),
    .waddr_i (exp_addr_i),
    .wdata_i (exp_wdata_i),
    .raddr_i (vec_count_q),
    .rdata_o (expData)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_i)    state_d = ST_RUN;
      ST_RUN:           if (lastAccept) state_d = ST_DONE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Mismatch report words are deliberately not cleared on run entry; they hold the latest failure.
  always_comb begin
    vec_count_d       = vec_count_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    mm_pulse_d        = 1'b0;
    mm_got_d          = mm_got_q;
    mm_exp_d          = mm_exp_q;
    if (runEntry) begin
      vec_count_d       = '0;
      err_count_d       = '0;
      first_err_valid_d = 1'b0;
      first_err_idx_d   = '0;
    end else if (accept) begin
      vec_count_d = vec_count_q + IDX_W'(1);
      if (mismatch) begin
        mm_pulse_d = 1'b1;
        mm_got_d   = rsp.rsp_data;
        mm_exp_d   = expData;
        if (err_count_q != {ERR_W{1'b1}}) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        if (!first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_idx_d   = vec_count_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      vec_count_q       <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      mm_pulse_q        <= 1'b0;
      mm_got_q          <= '0;
      mm_exp_q          <= '0;
    end else begin
      state_q           <= state_d;
      vec_count_q       <= vec_count_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
      mm_pulse_q        <= mm_pulse_d;
      mm_got_q          <= mm_got_d;
      mm_exp_q          <= mm_exp_d;
    end
  end

  assign rsp.rsp_ready     = running;
  assign busy_o            = running;
  assign done_o            = (state_q == ST_DONE);
  assign pass_o            = done_o && (err_count_q == '0);
  assign vec_count_o       = vec_count_q;
  assign err_count_o       = err_count_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_idx_o   = first_err_idx_q;
  assign mm_pulse_o        = mm_pulse_q;
  assign mm_got_o          = mm_got_q;
  assign mm_exp_o          = mm_exp_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// Randomised bench for vector_response_checker with a narrow error counter so saturation is reachable.
// Expected outputs are derived each cycle from the words accepted so far in the current run.
module tb_vector_response_checker;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 9;
  localparam int IDX_W   = 7;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic expWeI = 1'b0;
  logic [IDX_W-1:0] expAddrI = '0;
  logic [DATA_W-1:0] expWdataI = '0;
  logic startI = 1'b0;
  logic busyO, doneO, passO, firstErrValidO, mmPulseO;
  logic [IDX_W-1:0] vecCountO, firstErrIdxO;
  logic [ERR_W-1:0] errCountO;
  logic [DATA_W-1:0] mmGotO, mmExpO;

  int checks = 0;
  int failures = 0;
  int pulseTotal = 0;
  int readyTotal = 0;

  logic [DATA_W-1:0] vecTbl [DEPTH];
  logic [DATA_W-1:0] rspWords [DEPTH];

  // Reference state: the table, plus the words accepted in this run and what they were judged against.
  logic [DATA_W-1:0] tbl [DEPTH];
  logic [DATA_W-1:0] runWords [$];
  logic [DATA_W-1:0] runExpQ [$];
  bit mRun = 1'b0, mDone = 1'b0, acceptedLast = 1'b0;
  logic [DATA_W-1:0] mLastGot = '0, mLastExp = '0;

  always #5 clk = ~clk;

  vector_response_checker_if #(.DATA_W(DATA_W)) rspIf ();

  initial begin
    rspIf.rsp_valid = 1'b0;
    rspIf.rsp_data  = '0;
  end

  vector_response_checker #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .ERR_W  (ERR_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rsp               (rspIf.slave),
    .exp_we_i          (expWeI),
    .exp_addr_i        (expAddrI),
    .exp_wdata_i       (expWdataI),
    .start_i           (startI),
    .busy_o            (busyO),
    .done_o            (doneO),
    .pass_o            (passO),
    .vec_count_o       (vecCountO),
    .err_count_o       (errCountO),
    .first_err_valid_o (firstErrValidO),
    .first_err_idx_o   (firstErrIdxO),
    .mm_pulse_o        (mmPulseO),
    .mm_got_o          (mmGotO),
    .mm_exp_o          (mmExpO)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRun <= 1'b0;
      mDone <= 1'b0;
      acceptedLast <= 1'b0;
      mLastGot <= '0;
      mLastExp <= '0;
      runWords.delete();
      runExpQ.delete();
    end else begin
      acceptedLast <= 1'b0;
      if (!mRun) begin
        if (expWeI && int'(expAddrI) < DEPTH) tbl[expAddrI] <= expWdataI;
        if (startI) begin
          mRun <= 1'b1;
          mDone <= 1'b0;
          runWords.delete();
          runExpQ.delete();
        end
      end else if (rspIf.rsp_valid) begin
        if (rspIf.rsp_data != tbl[runWords.size()]) begin
          mLastGot <= rspIf.rsp_data;
          mLastExp <= tbl[runWords.size()];
        end
        acceptedLast <= 1'b1;
        if (runWords.size() + 1 == DEPTH) begin
          mRun <= 1'b0;
          mDone <= 1'b1;
        end
        runExpQ.push_back(tbl[runWords.size()]);
        runWords.push_back(rspIf.rsp_data);
      end
    end
  end

  always @(negedge clk) begin
    int nErr;
    int fIdx;
    bit fValid;
    bit pulse;
    nErr = 0;
    fIdx = 0;
    fValid = 1'b0;
    foreach (runWords[i]) begin
      if (runWords[i] != runExpQ[i]) begin
        nErr++;
        if (!fValid) begin
          fValid = 1'b1;
          fIdx = i;
        end
      end
    end
    pulse = acceptedLast && (runWords.size() > 0) && (runWords[$] != runExpQ[$]);
    if (nErr > ERR_MAX) nErr = ERR_MAX;
    checkOutput("busy", 32'(busyO), 32'(mRun));
    checkOutput("rsp_ready", 32'(rspIf.rsp_ready), 32'(mRun));
    checkOutput("done", 32'(doneO), 32'(mDone));
    checkOutput("pass", 32'(passO), 32'(mDone && nErr == 0));
    checkOutput("vec_count", 32'(vecCountO), 32'(runWords.size()));
    checkOutput("err_count", 32'(errCountO), 32'(nErr));
    checkOutput("first_err_valid", 32'(firstErrValidO), 32'(fValid));
    checkOutput("first_err_idx", 32'(firstErrIdxO), 32'(fIdx));
    checkOutput("mm_pulse", 32'(mmPulseO), 32'(pulse));
    checkOutput("mm_got", 32'(mmGotO), 32'(mLastGot));
    checkOutput("mm_exp", 32'(mmExpO), 32'(mLastExp));
    pulseTotal += int'(mmPulseO);
    readyTotal += int'(rspIf.rsp_ready);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadTable(input bit withStart);
    expWeI = 1'b1;
    expAddrI = IDX_W'(16 + $urandom_range(0, 100));
    expWdataI = DATA_W'($urandom);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      expAddrI = IDX_W'(i);
      expWdataI = vecTbl[i];
      startI = withStart && (i == DEPTH - 1);
      tick();
    end
    expWeI = 1'b0;
    startI = 1'b0;
  endtask

  task automatic startRun();
    startI = 1'b1;
    tick();
    startI = 1'b0;
  endtask

  task automatic applyStimulus(input int nAccept, input int gapPct, input bit noise);
    int idx;
    int budget;
    bit v;
    bit wasReady;
    idx = 0;
    budget = 0;
    while (idx < nAccept && budget < 400) begin
      v = ($urandom_range(99) >= gapPct);
      rspIf.rsp_valid = v;
      rspIf.rsp_data = v ? rspWords[idx] : DATA_W'($urandom);
      if (noise) begin
        startI = ($urandom_range(3) == 0);
        expWeI = ($urandom_range(2) == 0);
        expAddrI = IDX_W'($urandom_range(DEPTH - 1));
        expWdataI = DATA_W'($urandom);
      end
      #3;
      wasReady = rspIf.rsp_ready;
      tick();
      if (v && wasReady) idx++;
      budget++;
    end
    rspIf.rsp_valid = 1'b0;
    startI = 1'b0;
    expWeI = 1'b0;
    if (idx < nAccept) begin
      checks++;
      failures++;
      $display("[TB] FAIL stream_timeout accepted=%0d required=%0d", idx, nAccept);
    end
  endtask

  task automatic setIdentity();
    for (int i = 0; i < DEPTH; i++) begin
      vecTbl[i] = DATA_W'(i);
      rspWords[i] = DATA_W'(i);
    end
  endtask

  initial begin
    int p0;
    int r0;
    #12;
    checkOutput("reset_busy", 32'(busyO), 0);
    checkOutput("reset_ready", 32'(rspIf.rsp_ready), 0);
    checkOutput("reset_vec_count", 32'(vecCountO), 0);
    checkOutput("reset_mm_got", 32'(mmGotO), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] clean identity run");
    setIdentity();
    loadTable(1'b0);
    p0 = pulseTotal;
    r0 = readyTotal;
    startRun();
    applyStimulus(DEPTH, 0, 1'b0);
    checkOutput("t1_done", 32'(doneO), 1);
    checkOutput("t1_pass", 32'(passO), 1);
    checkOutput("t1_err", 32'(errCountO), 0);
    checkOutput("t1_vec", 32'(vecCountO), 9);
    checkOutput("t1_ready_cycles", 32'(readyTotal - r0), 9);
    checkOutput("t1_pulses", 32'(pulseTotal - p0), 0);

    $display("[TB] two planted mismatches");
    rspWords[3] = 8'h13;
    rspWords[7] = 8'hFF;
    p0 = pulseTotal;
    startRun();
    applyStimulus(DEPTH, 0, 1'b0);
    checkOutput("t2_err", 32'(errCountO), 2);
    checkOutput("t2_first_idx", 32'(firstErrIdxO), 3);
    checkOutput("t2_pulses", 32'(pulseTotal - p0), 2);
    checkOutput("t2_mm_got", 32'(mmGotO), 32'hFF);
    checkOutput("t2_mm_exp", 32'(mmExpO), 32'h07);
    checkOutput("t2_pass", 32'(passO), 0);

    $display("[TB] gaps, start and write noise during run");
    setIdentity();
    startRun();
    applyStimulus(DEPTH, 40, 1'b1);
    checkOutput("t3_pass", 32'(passO), 1);
    startRun();
    applyStimulus(DEPTH, 30, 1'b0);
    checkOutput("t3_table_kept_pass", 32'(passO), 1);

    $display("[TB] saturating error counter");
    for (int i = 0; i < DEPTH; i++) rspWords[i] = ~vecTbl[i];
    startRun();
    applyStimulus(DEPTH, 10, 1'b0);
    checkOutput("t4_err_sat", 32'(errCountO), 3);
    checkOutput("t4_first_idx", 32'(firstErrIdxO), 0);

    $display("[TB] reset mid-run");
    setIdentity();
    startRun();
    applyStimulus(4, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy_now", 32'(busyO), 0);
    checkOutput("t5_vec_now", 32'(vecCountO), 0);
    checkOutput("t5_err_now", 32'(errCountO), 0);
    checkOutput("t5_mm_got_now", 32'(mmGotO), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    startRun();
    applyStimulus(DEPTH, 20, 1'b0);
    checkOutput("t5_restart_pass", 32'(passO), 1);

    $display("[TB] restart from DONE with fresh responses");
    rspWords[0] = 8'hAA;
    startRun();
    checkOutput("t6_vec_cleared", 32'(vecCountO), 0);
    checkOutput("t6_err_cleared", 32'(errCountO), 0);
    checkOutput("t6_fev_cleared", 32'(firstErrValidO), 0);
    applyStimulus(DEPTH, 0, 1'b0);
    checkOutput("t6_err", 32'(errCountO), 1);
    checkOutput("t6_first_idx", 32'(firstErrIdxO), 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        vecTbl[i] = DATA_W'($urandom);
        rspWords[i] = ($urandom_range(99) < 30) ? DATA_W'($urandom) : vecTbl[i];
      end
      loadTable(1'b1);
      applyStimulus(DEPTH, 25, 1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
